i2s_master_tx: RTL

- Parallel-to-I2S serializer; the source stage feeding the I2S receiver / PCM56 fan-out block on the board.
- Generates BCK, LRCK and DATA from the MCK domain.
- Accepts stereo 24-bit samples through a valid/ready handshake into a one-entry holding buffer.
- Used for internal test playback and loopback in place of an external I2S source.

---
 rtl/i2s_pkg.sv | 18 +
 rtl/i2s_master_tx_if.sv | 16 +
 rtl/i2s_bck_div.sv | 46 ++++
 rtl/i2s_master_tx.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared widths, channel enum and slot-to-bit helper for i2s_master_tx
package i2s_pkg;

  localparam int FRAME_W         = 24;
  localparam int SLOT_W          = 32;
  localparam int MCK_PER_BCK_DEF = 4;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } ch_e;

  // One-bit I2S delay: slot position 1 carries the sample MSB.
  function automatic int data_bit_idx(input int slot_pos, input int frame_w);
    return frame_w - slot_pos;
  endfunction

endpackage

// File: rtl/i2s_master_tx_if.sv
// rtl/i2s_master_tx_if.sv - stereo sample valid/ready handshake into i2s_master_tx
interface i2s_master_tx_if
  import i2s_pkg::*;
#(
  parameter int FRAME = FRAME_W
);

  logic [FRAME-1:0] sample_l;
  logic [FRAME-1:0] sample_r;
  logic             valid;
  logic             ready;

  modport master (output sample_l, output sample_r, output valid, input ready);
  modport slave  (input sample_l, input sample_r, input valid, output ready);

endinterface

// File: rtl/i2s_bck_div.sv
// rtl/i2s_bck_div.sv - MCK-to-BCK divider: registered bck level, bit tick and fall strobe
module i2s_bck_div
  import i2s_pkg::*;
#(
  parameter int MCK_PER_BCK = MCK_PER_BCK_DEF
) (
  input  logic mck_i,
  input  logic rst_i,
  input  logic en_i,
  output logic bck_o,
  output logic tick_o,
  output logic fall_o
);

  localparam int            DW       = (MCK_PER_BCK > 2) ? $clog2(MCK_PER_BCK) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(MCK_PER_BCK - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(MCK_PER_BCK / 2);

  logic [DW-1:0] div_q, div_d;
  logic          bck_q, bck_d;

  always_comb begin
    div_d = '0;
    bck_d = 1'b0;
    if (en_i) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
      bck_d = (div_q >= DIV_HALF);
    end
  end

  always_ff @(posedge mck_i or negedge rst_i) begin
    if (!rst_i) begin
      div_q <= '0;
      bck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      bck_q <= bck_d;
    end
  end

  // tick advances the bit counter; fall marks the edge where bck_o drops
  assign tick_o = en_i & (div_q == DIV_LAST);
  assign fall_o = en_i & (div_q == '0);
  assign bck_o  = bck_q;

endmodule

// File: rtl/i2s_master_tx.sv
// rtl/i2s_master_tx.sv - parallel-to-I2S serializer with one-entry holding buffer
// Optional I2S_TX_REPEAT_EN: underrun resends the last loaded pair instead of zeros.
module i2s_master_tx
  import i2s_pkg::*;
#(
  parameter int FRAME       = FRAME_W,
  parameter int SLOT        = SLOT_W,
  parameter int MCK_PER_BCK = MCK_PER_BCK_DEF
) (
  input  logic             mck_i,
  input  logic             rst_i,
  input  logic             en_i,
  i2s_master_tx_if.slave   src_if,
  output logic             bck_o,
  output logic             lrck_o,
  output logic             data_o,
  output logic             frame_o,
  output logic             underrun_o
);

  localparam int            BW     = $clog2(2 * SLOT);
  localparam int            FIW    = $clog2(FRAME);
  localparam logic [BW-1:0] B_LAST = BW'(2 * SLOT - 1);
  localparam logic [BW-1:0] B_SLOT = BW'(SLOT);

  logic             tick, fall, load, write;
  logic [BW-1:0]    b_q, b_d;
  logic             run_q, run_d;
  logic             full_q, full_d;
  logic [FRAME-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic [FRAME-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;
  logic [FRAME-1:0] rep_l, rep_r;
  logic             lrck_q, lrck_d, data_q, data_d;
  logic             frame_q, frame_d, underrun_q, underrun_d;
  logic [BW-1:0]    slot_pos;
  logic [FIW-1:0]   bit_idx;
  ch_e              ch;
  logic             data_bit;

  i2s_bck_div #(.MCK_PER_BCK(MCK_PER_BCK)) u_div (
    .mck_i  (mck_i),
    .rst_i  (rst_i),
    .en_i   (en_i),
    .bck_o  (bck_o),
    .tick_o (tick),
    .fall_o (fall)
  );

`ifdef I2S_TX_REPEAT_EN
  logic [FRAME-1:0] last_l_q, last_r_q;

  always_ff @(posedge mck_i or negedge rst_i) begin
    if (!rst_i) begin
      last_l_q <= '0;
      last_r_q <= '0;
    end else if (load && full_q) begin
      last_l_q <= buf_l_q;
      last_r_q <= buf_r_q;
    end
  end

  assign rep_l = last_l_q;
  assign rep_r = last_r_q;
`else
  assign rep_l = '0;
  assign rep_r = '0;
`endif

  always_comb begin
    ch       = (b_q >= B_SLOT) ? CH_RIGHT : CH_LEFT;
    slot_pos = (ch == CH_RIGHT) ? b_q - B_SLOT : b_q;
    bit_idx  = FIW'(data_bit_idx(int'(slot_pos), FRAME));
    data_bit = 1'b0;
    if (slot_pos != '0 && int'(slot_pos) <= FRAME)
      data_bit = (ch == CH_RIGHT) ? frame_r_q[bit_idx] : frame_l_q[bit_idx];
  end

  // The first tick after enable loads a frame without advancing b.
  always_comb begin
    load  = tick & (~run_q | (b_q == B_LAST));
    write = src_if.valid & ~full_q;

    run_d = run_q;
    b_d   = b_q;
    if (!en_i) begin
      run_d = 1'b0;
      b_d   = '0;
    end else if (tick) begin
      run_d = 1'b1;
      b_d   = load ? '0 : b_q + BW'(1);
    end

    full_d  = write ? 1'b1 : (load ? 1'b0 : full_q);
    buf_l_d = write ? src_if.sample_l : buf_l_q;
    buf_r_d = write ? src_if.sample_r : buf_r_q;

    frame_l_d = frame_l_q;
    frame_r_d = frame_r_q;
    if (load) begin
      frame_l_d = full_q ? buf_l_q : rep_l;
      frame_r_d = full_q ? buf_r_q : rep_r;
    end

    lrck_d = lrck_q;
    data_d = data_q;
    if (!en_i) begin
      lrck_d = 1'b0;
      data_d = 1'b0;
    end else if (fall && run_q) begin
      lrck_d = (ch == CH_RIGHT);
      data_d = data_bit;
    end

    frame_d    = load;
    underrun_d = load & ~full_q;
  end

  always_ff @(posedge mck_i or negedge rst_i) begin
    if (!rst_i) begin
      b_q        <= '0;
      run_q      <= 1'b0;
      full_q     <= 1'b0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
      frame_l_q  <= '0;
      frame_r_q  <= '0;
      lrck_q     <= 1'b0;
      data_q     <= 1'b0;
      frame_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      b_q        <= b_d;
      run_q      <= run_d;
      full_q     <= full_d;
      buf_l_q    <= buf_l_d;
      buf_r_q    <= buf_r_d;
      frame_l_q  <= frame_l_d;
      frame_r_q  <= frame_r_d;
      lrck_q     <= lrck_d;
      data_q     <= data_d;
      frame_q    <= frame_d;
      underrun_q <= underrun_d;
    end
  end

  assign src_if.ready = ~full_q;
  assign lrck_o       = lrck_q;
  assign data_o       = data_q;
  assign frame_o      = frame_q;
  assign underrun_o   = underrun_q;

endmodule
